// File: rtl/macro_seq_ctrl.sv
// rtl/macro_seq_ctrl.sv - CIM macro phase sequencer with signed accumulation (optional MACRO_SEQ_RELU_EN)
`ifndef MACRO_O_DW
`define MACRO_O_DW 8
`endif

module macro_seq_ctrl #(
    parameter int OUT_DW     = `MACRO_O_DW,
    parameter int ACC_DW     = OUT_DW + 2,
    parameter int SETUP_CYC  = 2,
    parameter int ADC_CYC    = 1,
    parameter int SETTLE_CYC = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0][8:0]              in_data,
    input  logic [1:0]                    cfg_last_ps,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [63:0][ACC_DW-1:0]       out_data,
    output logic                          busy,
    output logic                          mac_enable,
    output logic                          mac_adc,
    output logic [1:0]                    mac_chs_ps,
    output logic [31:0][8:0]              mac_data_in,
    input  logic [63:0][OUT_DW-1:0]       mac_data_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_CONV, S_SETTLE, S_CAPTURE, S_DONE
    } state_t;

    localparam int CW = 8;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [1:0]              phase_q, phase_d;
    logic [1:0]              last_q, last_d;
    logic [31:0][8:0]        win_q, win_d;
    logic [63:0][ACC_DW-1:0] acc_q, acc_d;

    function automatic logic [ACC_DW-1:0] sext(input logic [OUT_DW-1:0] x);
        return {{(ACC_DW-OUT_DW){x[OUT_DW-1]}}, x};
    endfunction

    // State, counters, latched window and accumulators; reset aborts any window in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            phase_q <= '0;
            last_q  <= '0;
            win_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            last_q  <= last_d;
            win_q   <= win_d;
            acc_q   <= acc_d;
        end
    end

    // Next-state logic: timed phase steps, per-phase capture into the accumulators
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        last_d  = last_q;
        win_d   = win_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    win_d   = in_data;
                    last_d  = cfg_last_ps;
                    phase_d = '0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == CW'(SETUP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_CONV;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CONV: begin
                if (cnt_q == CW'(ADC_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == CW'(SETTLE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CAPTURE: begin
                for (int i = 0; i < 64; i++) begin
                    acc_d[i] = acc_q[i] + sext(mac_data_out[i]);
                end
                if (phase_q == last_q) begin
                    state_d = S_DONE;
                end else begin
                    phase_d = phase_q + 2'd1;
                    state_d = S_SETUP;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready    = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign mac_enable  = (state_q == S_SETUP) || (state_q == S_CONV) ||
                         (state_q == S_SETTLE) || (state_q == S_CAPTURE);
    assign mac_adc     = (state_q == S_CONV);
    assign mac_chs_ps  = phase_q;
    assign mac_data_in = win_q;

    // Output sums, optionally clamped at zero for negative totals
    always_comb begin
        out_data = '0;
        for (int i = 0; i < 64; i++) begin
`ifdef MACRO_SEQ_RELU_EN
            out_data[i] = acc_q[i][ACC_DW-1] ? '0 : acc_q[i];
`else
            out_data[i] = acc_q[i];
`endif
        end
    end

endmodule

// File: tb/tb_macro_seq_ctrl.sv
// tb/tb_macro_seq_ctrl.sv - directed table-driven bench for macro_seq_ctrl
module tb_macro_seq_ctrl;

    localparam int OUT_DW = 8;
    localparam int ACC_DW = 10;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [31:0][8:0]         in_data = '0;
    logic [1:0]               cfg_last_ps = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [63:0][ACC_DW-1:0]  out_data;
    logic                     busy;
    logic                     mac_enable;
    logic                     mac_adc;
    logic [1:0]               mac_chs_ps;
    logic [31:0][8:0]         mac_data_in;
    logic [63:0][OUT_DW-1:0]  mac_data_out = '0;

    int n_cmp = 0;
    int n_err = 0;

    macro_seq_ctrl #(
        .OUT_DW(OUT_DW), .ACC_DW(ACC_DW),
        .SETUP_CYC(2), .ADC_CYC(1), .SETTLE_CYC(2)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cfg_last_ps(cfg_last_ps),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .mac_enable(mac_enable), .mac_adc(mac_adc),
        .mac_chs_ps(mac_chs_ps), .mac_data_in(mac_data_in),
        .mac_data_out(mac_data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] last;
        int         v0;
        int         vn;
        int         e0;
        int         en;
        int         lat;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int post(input int x);
`ifdef MACRO_SEQ_RELU_EN
        return (x < 0) ? 0 : x;
`else
        return x;
`endif
    endfunction

    function automatic logic [31:0][8:0] pattern(input int seed);
        logic [31:0][8:0] w;
        for (int i = 0; i < 32; i++) w[i] = 9'(i * 37 + seed * 11 + 1);
        return w;
    endfunction

    task automatic set_dout(input int v0, input int vn);
        for (int i = 0; i < 64; i++) mac_data_out[i] = OUT_DW'(vn);
        mac_data_out[0] = OUT_DW'(v0);
    endtask

    function automatic int sum_of(input int ch);
        return $signed(out_data[ch]);
    endfunction

    task automatic run_window(input vec_t v, input string tag);
        int         cyc;
        int         adc_n;
        logic [1:0] chs [0:7];
        int         order_ok;
        logic [31:0][8:0] w;
        set_dout(v.v0, v.vn);
        w = pattern(v.lat);
        @(negedge clk);
        chk({tag, " in_ready_idle"}, int'(in_ready), 1);
        in_valid    = 1'b1;
        cfg_last_ps = v.last;
        in_data     = w;
        @(posedge clk);
        @(negedge clk);
        in_valid    = 1'b0;
        cfg_last_ps = ~v.last;
        in_data     = '0;
        chk({tag, " win_latched"}, int'(mac_data_in == w), 1);
        chk({tag, " in_ready_busy"}, int'(in_ready), 0);
        cyc   = 1;
        adc_n = 0;
        while (cyc < 200) begin
            if (out_valid) break;
            if (mac_adc) begin
                if (adc_n < 8) chs[adc_n] = mac_chs_ps;
                adc_n++;
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"}, cyc, v.lat);
        chk({tag, " adc_pulses"}, adc_n, int'(v.last) + 1);
        order_ok = 1;
        for (int k = 0; k < adc_n && k < 8; k++) if (chs[k] != 2'(k)) order_ok = 0;
        chk({tag, " chs_order"}, order_ok, 1);
        chk({tag, " out0"}, sum_of(0), post(v.e0));
        chk({tag, " out63"}, sum_of(63), post(v.en));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " out_valid_drop"}, int'(out_valid), 0);
        chk({tag, " in_ready_back"}, int'(in_ready), 1);
    endtask

    vec_t vecs [6];

    initial begin
        int cyc;

        vecs[0] = '{last: 2'd3, v0:    5, vn:   5, e0:   20, en:  20, lat: 25};
        vecs[1] = '{last: 2'd0, v0:   -3, vn:   1, e0:   -3, en:   1, lat:  7};
        vecs[2] = '{last: 2'd3, v0:  127, vn: 127, e0:  508, en: 508, lat: 25};
        vecs[3] = '{last: 2'd3, v0: -128, vn:  -1, e0: -512, en:  -4, lat: 25};
        vecs[4] = '{last: 2'd1, v0:    7, vn:  -2, e0:   14, en:  -4, lat: 13};
        vecs[5] = '{last: 2'd2, v0:   -5, vn:   3, e0:  -15, en:   9, lat: 19};

        repeat (3) @(negedge clk);
        chk("rst in_ready", int'(in_ready), 1);
        chk("rst busy", int'(busy), 0);
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst mac_enable", int'(mac_enable), 0);
        chk("rst out0", sum_of(0), 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_window(vecs[i], $sformatf("vec%0d", i));

        // DONE held by back-pressure; in_valid in DONE is ignored
        set_dout(3, -4);
        @(negedge clk);
        in_valid = 1'b1; cfg_last_ps = 2'd1; in_data = pattern(9);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin @(negedge clk); cyc++; end
        chk("hold reached_done", int'(out_valid), 1);
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("hold out_valid", int'(out_valid), 1);
            chk("hold out0", sum_of(0), post(6));
            chk("hold out63", sum_of(63), post(-8));
            chk("hold in_ready", int'(in_ready), 0);
            chk("hold mac_enable", int'(mac_enable), 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("hold released_idle", int'(busy), 0);

        // Reset during CONV of phase 2, then a clean window
        set_dout(50, 50);
        in_valid = 1'b1; cfg_last_ps = 2'd3; in_data = pattern(4);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!(mac_adc && mac_chs_ps == 2'd2) && cyc < 100) begin @(negedge clk); cyc++; end
        chk("abort reached_conv2", int'(mac_adc && mac_chs_ps == 2'd2), 1);
        rst = 1'b1;
        #1;
        chk("abort in_ready", int'(in_ready), 1);
        chk("abort busy", int'(busy), 0);
        chk("abort mac_enable", int'(mac_enable), 0);
        chk("abort mac_adc", int'(mac_adc), 0);
        chk("abort chs_ps", int'(mac_chs_ps), 0);
        chk("abort data_in", int'(mac_data_in == '0), 1);
        chk("abort out63", sum_of(63), 0);
        @(negedge clk);
        rst = 1'b0;
        run_window('{last: 2'd0, v0: 2, vn: -7, e0: 2, en: -7, lat: 7}, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
